// File: rtl/div_by_five_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_by_five_pkg
// Description : FSM states and mod-5 fold / check-nibble helpers shared by the
//               divisible-by-five encoder and detector.
// Revision    : 1.0
// ============================================================================
package div_by_five_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // (acc + nibble) mod 5 for acc in 0..4 and nibble in 0..15, so sum <= 19;
  // one compare-subtract pass is exact over that range.
  function automatic logic [2:0] fold_mod5(input logic [2:0] acc, input logic [3:0] nibble);
    logic [4:0] sum;
    sum = {2'b00, acc} + {1'b0, nibble};
    if (sum >= 5'd15)      sum = sum - 5'd15;
    else if (sum >= 5'd10) sum = sum - 5'd10;
    else if (sum >= 5'd5)  sum = sum - 5'd5;
    return 3'(sum);
  endfunction

  function automatic logic [3:0] check_nibble(input logic [2:0] r);
    logic [3:0] c;
    case (r)
      3'd1:    c = 4'd4;
      3'd2:    c = 4'd3;
      3'd3:    c = 4'd2;
      3'd4:    c = 4'd1;
      default: c = 4'd0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_by_five_encoder_mod5_fold.sv
`default_nettype none
// ============================================================================
// Module      : mod5_fold
// Description : Combinational single-nibble residue fold, acc_next = (acc+nibble) mod 5.
// Revision    : 1.0
// ============================================================================
module mod5_fold
  import div_by_five_pkg::*;
(
  input  logic [2:0] acc,
  input  logic [3:0] nibble,
  output logic [2:0] acc_next
);

  assign acc_next = fold_mod5(acc, nibble);

endmodule
`default_nettype wire

// File: rtl/div_by_five_encoder.sv
`default_nettype none
// ============================================================================
// Module      : div_by_five_encoder
// Description : Serially folds a message mod 5 (16 == 1 mod 5) and appends a
//               check nibble so the code word {msg, c} is a multiple of five.
// Revision    : 1.0
// ============================================================================
module div_by_five_encoder
  import div_by_five_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] in_msg,
  input  logic                 in_val,
  output logic                 in_rdy,
  output logic [BIT_WIDTH+3:0] out_msg,
  output logic                 out_val,
  input  logic                 out_rdy
);

  localparam int NIBBLES = BIT_WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  if ((BIT_WIDTH % 4 != 0) || (BIT_WIDTH < 8)) begin : g_bad_width
    $error("div_by_five_encoder: BIT_WIDTH must be a multiple of 4 and >= 8");
  end

  state_e                 state_q, state_d;
  logic [BIT_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BIT_WIDTH-1:0]   msg_q, msg_d;
  logic [2:0]             acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_WIDTH+3:0]   out_msg_q, out_msg_d;
  logic                   out_val_q, out_val_d;
  logic [2:0]             fold_acc;

  mod5_fold u_fold (
    .acc      (acc_q),
    .nibble   (shreg_q[3:0]),
    .acc_next (fold_acc)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    msg_d     = msg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_msg_d = out_msg_q;
    out_val_d = out_val_q;
    case (state_q)
      IDLE: begin
        if (in_val) begin
          shreg_d = in_msg;
          msg_d   = in_msg;
          acc_d   = 3'd0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = fold_acc;
        shreg_d = {4'b0000, shreg_q[BIT_WIDTH-1:4]};
        cnt_d   = cnt_q + CNT_W'(1);
        // Last nibble folds on this edge, so the code word uses fold_acc directly.
        if (cnt_q == LAST_CNT) begin
          out_msg_d = {msg_q, check_nibble(fold_acc)};
          out_val_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_rdy) begin
          out_val_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        out_val_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      msg_q     <= '0;
      acc_q     <= 3'd0;
      cnt_q     <= '0;
      out_msg_q <= '0;
      out_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      msg_q     <= msg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_msg_q <= out_msg_d;
      out_val_q <= out_val_d;
    end
  end

  assign in_rdy  = (state_q == IDLE) && !rst;
  assign out_msg = out_msg_q;
  assign out_val = out_val_q;

endmodule
`default_nettype wire

// File: tb/tb_div_by_five_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_by_five_encoder
// Description : Self-checking bench for div_by_five_encoder against an
//               arithmetic mod-5 reference.
// Revision    : 1.0
// ============================================================================
module tb_div_by_five_encoder;

  logic        clk;
  logic        rst;
  logic [31:0] in_msg;
  logic        in_val;
  logic        in_rdy;
  logic [35:0] out_msg;
  logic        out_val;
  logic        out_rdy;

  int checks   = 0;
  int failures = 0;

  div_by_five_encoder #(.BIT_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_msg  (in_msg),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .out_msg (out_msg),
    .out_val (out_val),
    .out_rdy (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: code word = 16*msg + c with c making the total divisible by 5.
  function automatic logic [35:0] ref_code(input logic [31:0] m);
    longint unsigned r;
    longint unsigned c;
    r = longint'(m) % 5;
    c = (5 - r) % 5;
    return {m, c[3:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one message with out_rdy=1; checks latency, code word and divisibility.
  task automatic run_msg(input logic [31:0] m, input string tag);
    int n;
    logic [35:0] exp;
    exp = ref_code(m);
    n = 0;
    while (!in_rdy && n < 30) begin tick(); n++; end
    check({tag, "_in_rdy"}, 64'(in_rdy), 64'd1);
    in_msg = m;
    in_val = 1'b1;
    tick();
    in_val = 1'b0;
    in_msg = $urandom;
    n = 0;
    while (!out_val && n < 30) begin tick(); n++; end
    check({tag, "_latency"}, 64'(n), 64'd8);
    check({tag, "_code"}, 64'(out_msg), 64'(exp));
    check({tag, "_div5"}, 64'(out_msg % 36'd5), 64'd0);
    if (exp[3:0] != 4'd4)
      check({tag, "_flip_nondiv"}, 64'((out_msg ^ 36'd1) % 36'd5 != 0), 64'd1);
    tick();
    check({tag, "_back_idle"}, {62'd0, in_rdy, out_val}, 64'd2);
  endtask

  initial begin
    int n;
    int outs;
    logic [35:0] held;
    rst     = 1'b1;
    in_msg  = '0;
    in_val  = 1'b0;
    out_rdy = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_in_rdy", 64'(in_rdy), 64'd0);
    check("rst_out_val", 64'(out_val), 64'd0);
    check("rst_out_msg", 64'(out_msg), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_rdy", 64'(in_rdy), 64'd1);

    // Directed vectors
    run_msg(32'h0000_0007, "m07");
    run_msg(32'h1234_5678, "m12345678");
    run_msg(32'h0000_0001, "m01");
    run_msg(32'hFFFF_FFFF, "mones");
    run_msg(32'h0000_0000, "mzero");
    check("const_07", 64'(ref_code(32'h7)), 64'h073);

    // Backpressure in DONE with a competing in_val
    out_rdy = 1'b0;
    in_msg  = 32'hDEAD_BEEF;
    in_val  = 1'b1;
    tick();
    in_val  = 1'b0;
    n = 0;
    while (!out_val && n < 30) begin tick(); n++; end
    check("bp_latency", 64'(n), 64'd8);
    held = out_msg;
    check("bp_code", 64'(held), 64'(ref_code(32'hDEAD_BEEF)));
    for (int i = 0; i < 5; i++) begin
      in_val = 1'b1;
      in_msg = 32'h0BAD_F00D + 32'(i);
      tick();
      check("bp_out_val", 64'(out_val), 64'd1);
      check("bp_hold", 64'(out_msg), 64'(held));
      check("bp_in_rdy", 64'(in_rdy), 64'd0);
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    tick();
    check("bp_release", {62'd0, in_rdy, out_val}, 64'd2);

    // Reset at CALC cycle 3 discards the message
    in_msg = 32'hCAFE_1234;
    in_val = 1'b1;
    tick();
    in_val = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_in_rdy_low", 64'(in_rdy), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_state", {26'd0, in_rdy, out_val, out_msg}, {26'd0, 1'b1, 1'b0, 36'd0});
    outs = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_val) outs++;
    end
    check("midrst_no_output", 64'(outs), 64'd0);
    run_msg(32'hA5A5_5A5A, "after_rst");

    // in_val held high: one acceptance per IDLE visit (10-cycle round trip)
    in_msg = 32'h8765_4321;
    in_val = 1'b1;
    outs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_val) begin
        outs++;
        check("hold_code", 64'(out_msg), 64'(ref_code(32'h8765_4321)));
      end
    end
    in_val = 1'b0;
    check("hold_count", 64'(outs), 64'd3);
    tick();
    tick();

    // Random loopback
    for (int i = 0; i < 1000; i++) begin
      run_msg($urandom, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_by_five_encoder.md
Name: div_by_five_encoder

Overview:
- Transmit-side companion to the divisible-by-five detector.
- Accepts a BIT_WIDTH message over a val/rdy handshake and computes its residue mod 5 serially, one nibble per cycle, using 16 ≡ 1 (mod 5).
- Emits a (BIT_WIDTH+4)-bit code word {msg, c}, where the check nibble c makes the code word an exact multiple of five.
- The detector downstream then reports divisible=1 for every uncorrupted code word.

Parameters:
- BIT_WIDTH, 32, message width in bits; must be a multiple of 4 and ≥ 8 (elaboration-time assertion).
- NIBBLES, BIT_WIDTH/4, derived localparam; number of serial fold cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_msg  input  BIT_WIDTH  message to encode; sampled only on in handshake
- in_val  input  1  in_msg valid
- in_rdy  output  1  encoder can accept a message
- out_msg  output  BIT_WIDTH+4  code word {msg, c}
- out_val  output  1  out_msg valid
- out_rdy  input  1  sink accepts out_msg

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE; out_val=0; out_msg=0; residue acc=0; nibble counter=0.
  - in_rdy is forced 0 while rst is high.
  - Reset mid-CALC or mid-DONE discards the message; no output is produced for it.
- States:
  - IDLE:
    - in_rdy=1, out_val=0.
    - On in_val&in_rdy: latch in_msg into the shift register and the message register, acc←0, cnt←0, go to CALC.
  - CALC:
    - in_rdy=0, out_val=0.
    - Each cycle: acc←(acc + shreg[3:0]) mod 5; shreg shifts right 4; cnt←cnt+1.
    - When cnt==NIBBLES-1, the last nibble folds on that edge, out_msg is loaded, and the state goes to DONE.
  - DONE:
    - out_val=1, in_rdy=0.
    - out_msg holds {msg, c}, with c = (5 − r) mod 5 zero-extended to 4 bits and r the final acc.
    - Values of c by r: r=0→0, 1→4, 2→3, 3→2, 4→1.
    - On out_val&out_rdy: go to IDLE.
- Latency:
  - Handshake accepted at edge k; out_val rises after edge k+NIBBLES and stays high until the out handshake.
  - The earliest next acceptance is the edge after the out handshake.
  - One message in flight; no overlap.
- Arithmetic:
  - acc stays in 0..4 at all times.
  - The fold input is 3-bit acc plus a 4-bit nibble (range 0..19); reduce it exactly mod 5. A lookup or compare-subtract is allowed; a divider is not.
  - Correctness follows because {msg,c} = 16·msg + c ≡ msg + c ≡ r + c ≡ 0 (mod 5).
- Handshake rules:
  - out_msg is stable while out_val=1 and out_rdy=0.
  - in_msg and in_val are ignored outside IDLE.
  - out_rdy is ignored outside DONE.
  - out_val does not depend combinationally on out_rdy.
  - in_rdy is a function of state (and rst) only.
- Boundaries:
  - msg=0 → c=0.
  - All-ones msg: the fold must not overflow.
  - in_val held high continuously: exactly one message is accepted per IDLE visit.

Decomposition:
- Package div_by_five_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Function or constant table for (acc+nibble) mod 5.
  - Function for check nibble c from r.
  - Shared with the detector so both ends use the same fold.
- Sub-module mod5_fold, purely combinational:
  - Inputs: acc[2:0], nibble[3:0]. Output: acc_next[2:0].
  - Instantiated once in the datapath.
- Top:
  - FSM plus counter.
  - Datapath: shift register, message register, acc, output register.

Test Plan:
- msg=0x00000007, out_rdy=1 → out_val after 8 cycles, out_msg=0x073 (115=5·23), then in_rdy=1 the next cycle.
- msg=0x12345678 → nibble sum 36, r=1, c=4, out_msg=0x123456784; msg=0x00000001 → out_msg=0x000000014.
- msg=0xFFFFFFFF → r=0, c=0, out_msg=0xFFFFFFFF0; msg=0 → out_msg=0.
- Backpressure: hold out_rdy=0 for 5 cycles in DONE → out_val=1 and out_msg unchanged throughout; a new in_val with a different in_msg during that time is not accepted (in_rdy=0).
- Assert rst for 1 cycle at CALC cycle 3 → next cycle state IDLE, out_val=0, out_msg=0, in_rdy=1; the following message encodes correctly.
- Loopback: 1000 random msgs into the encoder, chained into the detector → every detector result divisible=1; flipping bit 0 of the code word (c≠4 cases) → divisible=0.
